// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and sequencer for the single-ported data memory
module dmem_arbiter #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024
) (
  input  logic              mem_clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [DATA_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [DATA_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

  state_t            state, state_nx;
  logic              last_winner;
  logic              id_q, we_q, err_q;
  logic [DATA_W-1:0] addr_q, wdata_q;

  logic              any_req, tie, win;
  logic              win_we;
  logic [DATA_W-1:0] win_addr, win_wdata;
  logic              win_err;

  always_comb begin
    any_req   = p0_req | p1_req;
    tie       = p0_req & p1_req;
    // On a tie the port that did not win the last tie goes first
    win       = tie ? ~last_winner : p1_req;
    win_we    = win ? p1_we    : p0_we;
    win_addr  = win ? p1_addr  : p0_addr;
    win_wdata = win ? p1_wdata : p0_wdata;
    win_err   = (win_addr[2:0] != 3'b000) || ((win_addr >> 3) >= DEPTH_W);
  end

  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        id_q    <= win;
        we_q    <= win_we;
        err_q   <= win_err;
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
        if (tie) last_winner <= win;
      end
    end
  end

  always_comb begin
    state_nx         = state;
    p0_gnt           = 1'b0;
    p1_gnt           = 1'b0;
    p0_done          = 1'b0;
    p1_done          = 1'b0;
    p0_err           = 1'b0;
    p1_err           = 1'b0;
    p0_rdata         = '0;
    p1_rdata         = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_addr         = '0;
    mem_write_data   = '0;
    busy             = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) state_nx = ACCESS;
      end
      ACCESS: begin
        p0_gnt = ~id_q;
        p1_gnt = id_q;
        // Errored accesses still walk the sequence but never reach memory
        if (!err_q) begin
          mem_addr         = addr_q;
          mem_write_data   = wdata_q;
          mem_read_enable  = ~we_q;
          mem_write_enable = we_q;
        end
        state_nx = RESP;
      end
      RESP: begin
        p0_done = ~id_q;
        p1_done = id_q;
        p0_err  = ~id_q & err_q;
        p1_err  = id_q & err_q;
        if (!we_q && !err_q) begin
          if (id_q) p1_rdata = mem_read_data;
          else      p0_rdata = mem_read_data;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural memory and arbitration model
module tb_dmem_arbiter;

  localparam int DW    = 64;
  localparam int DEPTH = 1024;
  localparam int S_IDLE = 0, S_ACC = 1, S_RESP = 2;

  typedef struct {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic          mem_clk = 1'b0;
  logic          reset;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [DW-1:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic          p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_read_enable, mem_write_enable, busy;
  logic [DW-1:0] mem_addr, mem_write_data, mem_read_data;

  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  req_t          q0[$], q1[$];
  int            n_chk = 0, n_fail = 0;

  dmem_arbiter #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .mem_clk(mem_clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  always #5 mem_clk = ~mem_clk;

  // Single-ported memory with a registered read port
  always @(posedge mem_clk) begin
    if (mem_write_enable) mem[mem_addr[12:3]] = mem_write_data;
    if (mem_read_enable)  mem_read_data <= mem[mem_addr[12:3]];
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, DW'({busy, p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err,
                            mem_read_enable, mem_write_enable}), '0);
    chk({tag, "_mem_addr"}, mem_addr, '0);
    chk({tag, "_mem_wdata"}, mem_write_data, '0);
    chk({tag, "_rdata"}, p0_rdata | p1_rdata, '0);
  endtask

  task automatic do_req(input bit p, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    bit   seen;
    r.we = we; r.addr = a; r.wdata = d;
    seen = 1'b0;
    if (!p) begin p0_we = we; p0_addr = a; p0_wdata = d; p0_req = 1'b1; q0.push_back(r); end
    else    begin p1_we = we; p1_addr = a; p1_wdata = d; p1_req = 1'b1; q1.push_back(r); end
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge mem_clk);
      seen = p ? p1_gnt : p0_gnt;
    end
    chk(p ? "p1_gnt_wait" : "p0_gnt_wait", DW'(seen), DW'(1));
    step();
    if (!p) p0_req = 1'b0; else p1_req = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return DW'($urandom_range(0, 15)) * 8 + DW'($urandom_range(1, 7));
    if (k == 1) return 64'h2000 + DW'($urandom_range(0, 31)) * 8;
    if (k == 2) return {32'h1, 32'h0};
    return DW'($urandom_range(0, 15)) * 8;
  endfunction

  // Monitor: predicts each cycle from the requests seen at the previous sampling point
  initial begin : monitor
    int   st, idx;
    bit   rr, pr0, pr1, wport, e_err, act;
    req_t cur;
    st = S_IDLE; rr = 1'b1; pr0 = 1'b0; pr1 = 1'b0; wport = 1'b0;
    cur.we = 1'b0; cur.addr = '0; cur.wdata = '0;
    forever begin
      @(negedge mem_clk);
      if (reset) begin
        st = S_IDLE;
        rr = 1'b1;
      end else begin
        case (st)
          S_IDLE: if (pr0 || pr1) begin
            wport = (pr0 && pr1) ? !rr : pr1;
            if (pr0 && pr1) rr = wport;
            if (!wport && q0.size() > 0)     cur = q0.pop_front();
            else if (wport && q1.size() > 0) cur = q1.pop_front();
            else chk("grant_without_request", DW'(1), DW'(0));
            st = S_ACC;
          end
          S_ACC:   st = S_RESP;
          default: st = S_IDLE;
        endcase
        e_err = (cur.addr % 8 != 0) || (cur.addr / 8 >= DW'(DEPTH));
        idx   = e_err ? 0 : int'(cur.addr / 8);
        act   = (st == S_ACC) && !e_err;
        chk("busy", DW'(busy), DW'(st != S_IDLE));
        chk("p0_gnt", DW'(p0_gnt), DW'(st == S_ACC && !wport));
        chk("p1_gnt", DW'(p1_gnt), DW'(st == S_ACC && wport));
        chk("mem_read_enable", DW'(mem_read_enable), DW'(act && !cur.we));
        chk("mem_write_enable", DW'(mem_write_enable), DW'(act && cur.we));
        if (!(st == S_ACC && e_err)) begin
          chk("mem_addr", mem_addr, act ? cur.addr : '0);
          chk("mem_write_data", mem_write_data, act ? cur.wdata : '0);
        end
        chk("p0_done", DW'(p0_done), DW'(st == S_RESP && !wport));
        chk("p1_done", DW'(p1_done), DW'(st == S_RESP && wport));
        chk("p0_rdata", p0_rdata,
            (st == S_RESP && !wport && !cur.we && !e_err) ? ref_mem[idx] : '0);
        chk("p1_rdata", p1_rdata,
            (st == S_RESP && wport && !cur.we && !e_err) ? ref_mem[idx] : '0);
        if (st == S_RESP) begin
          chk(wport ? "p1_err" : "p0_err", DW'(wport ? p1_err : p0_err), DW'(e_err));
          if (cur.we && !e_err) ref_mem[idx] = cur.wdata;
        end
      end
      pr0 = p0_req;
      pr1 = p1_req;
    end
  end

  initial begin : stim
    bit seen;
    reset = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = {32'hA5A5_0000 | 32'(i), 32'(i)};
      ref_mem[i] = mem[i];
    end
    mem[2] = 64'hDEADBEEF; ref_mem[2] = 64'hDEADBEEF;
    repeat (2) @(negedge mem_clk);
    check_all_zero("reset");
    #2 reset = 1'b0;
    step();

    // Single load, then store/load on port 1
    do_req(1'b0, 1'b0, 64'h10, '0);
    do_req(1'b1, 1'b1, 64'h18, 64'h1234);
    do_req(1'b1, 1'b0, 64'h18, '0);

    // Both ports held continuously
    fork
      begin for (int i = 0; i < 4; i++) do_req(1'b0, 1'b0, 64'h10, '0); end
      begin for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, 64'h18, '0); end
    join

    // Misaligned and out-of-range
    do_req(1'b0, 1'b0, 64'h0C, '0);
    do_req(1'b1, 1'b1, 64'h2000, 64'hBAD);
    do_req(1'b0, 1'b1, 64'h0C, 64'hBAD);
    repeat (3) step();

    // Reset during ACCESS of a store
    seen = 1'b0;
    p0_we = 1'b1; p0_addr = 64'h20; p0_wdata = 64'hFF; p0_req = 1'b1;
    q0.push_back('{1'b1, 64'h20, 64'hFF});
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge mem_clk);
      seen = p0_gnt;
    end
    chk("rst_gnt_wait", DW'(seen), DW'(1));
    #2 reset = 1'b1; p0_req = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge mem_clk);
    #2 reset = 1'b0;
    step();
    fork
      do_req(1'b0, 1'b0, 64'h20, '0);
      do_req(1'b1, 1'b0, 64'h28, '0);
    join

    // Port 1 raises and withdraws its request while port 0 is being served
    fork
      do_req(1'b0, 1'b0, 64'h8, '0);
      begin
        for (int i = 0; i < 30 && !p0_gnt; i++) @(negedge mem_clk);
        step();
        p1_we = 1'b1; p1_addr = 64'h30; p1_wdata = 64'h5555; p1_req = 1'b1;
        step();
        p1_req = 1'b0;
      end
    join
    repeat (6) step();

    // Randomised traffic from both ports
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) step();
          do_req(1'b0, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) step();
          do_req(1'b1, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
        end
      end
    join
    repeat (6) step();

    chk("q0_drained", DW'(q0.size()), '0);
    chk("q1_drained", DW'(q1.size()), '0);
    for (int i = 0; i < 32; i++) chk("mem_final", mem[i], ref_mem[i]);
    chk("mem_final_oob_guard", mem[DEPTH-1], ref_mem[DEPTH-1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
